// File: rtl/cache_fill_fsm.sv
// Cache line fill controller.
// On a miss, this block issues eight back-to-back 16-bit word reads for the
// 16-byte line that contains the missed address. It writes each returned word
// into the cache data array, counting only memory_data_valid pulses, so it
// does not rely on any particular memory latency. The tag/valid strobe is
// raised together with the eighth data write. A reset during a fill abandons
// the line without writing its tag, so a partial line is never marked valid.
module cache_fill_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        memory_data_valid,
  input  logic [15:0] memory_data_in,
  output logic        fsm_busy,
  output logic        memory_read,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic        write_tag_array,
  output logic [2:0]  word_num,
  output logic [15:0] cache_address,
  output logic [15:0] cache_data_out
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t      r_state;
  logic [11:0] r_base_line;   // line-aligned base address, bits [15:4]
  logic [3:0]  r_req_cnt;     // requests issued so far, 0..8
  logic [2:0]  r_rcv_cnt;     // words received so far, mod 8

  logic w_in_fill;
  logic w_req_issue;
  logic w_data_wr;
  logic w_last_wr;

  // Request issue and data receive run concurrently; only the receive side ends the fill
  always_comb begin
    w_in_fill   = (r_state == S_FILL);
    w_req_issue = w_in_fill && (r_req_cnt < 4'd8);
    w_data_wr   = w_in_fill && memory_data_valid;
    w_last_wr   = w_data_wr && (r_rcv_cnt == 3'd7);
  end

  // State, line base and both counters; reset abandons any fill in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_base_line <= '0;
      r_req_cnt   <= '0;
      r_rcv_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (miss_detected) begin
            r_base_line <= miss_address[15:4];
            r_req_cnt   <= '0;
            r_rcv_cnt   <= '0;
            r_state     <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_req_issue) begin
            r_req_cnt <= r_req_cnt + 4'd1;
          end
          if (w_data_wr) begin
            r_rcv_cnt <= r_rcv_cnt + 3'd1;
          end
          if (w_last_wr) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs: a decode of the registered state plus the returned-data valid strobe
  always_comb begin
    fsm_busy         = w_in_fill;
    memory_read      = w_req_issue;
    memory_address   = w_req_issue ? {r_base_line, r_req_cnt[2:0], 1'b0} : '0;
    write_data_array = w_data_wr;
    write_tag_array  = w_last_wr;
    word_num         = w_in_fill ? r_rcv_cnt : '0;
    cache_address    = w_in_fill ? {r_base_line, r_rcv_cnt, 1'b0} : miss_address;
    cache_data_out   = memory_data_in;
  end

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset, sampled on the clk rising edge.
REQ-003 The block SHALL have the port miss_detected, input, 1 bit: the cache Miss indication for the current access.
REQ-004 The block SHALL have the port miss_address, input, 16 bits: the byte address that missed; bits [3:0] are ignored.
REQ-005 The block SHALL have the port memory_data_valid, input, 1 bit: memory returns one valid word this cycle.
REQ-006 The block SHALL have the port memory_data_in, input, 16 bits: the word returned by memory.
REQ-007 The block SHALL have the port fsm_busy, output, 1 bit: a fill is in progress, and the pipeline stalls.
REQ-008 The block SHALL have the port memory_read, output, 1 bit: issues a memory read request this cycle.
REQ-009 The block SHALL have the port memory_address, output, 16 bits: the memory request address.
REQ-010 The block SHALL have the port write_data_array, output, 1 bit: the cache data-array write strobe.
REQ-011 The block SHALL have the port write_tag_array, output, 1 bit: the cache tag/valid write strobe.
REQ-012 The block SHALL have the port word_num, output, 3 bits: the word index within the line for the data-array write.
REQ-013 The block SHALL have the port cache_address, output, 16 bits: the address presented to the cache during the fill.
REQ-014 The block SHALL have the port cache_data_out, output, 16 bits: the data presented to the cache Data_In.

Function
REQ-015 Line geometry SHALL be 16 bytes = 8 words of 16 bits; base = {miss_address[15:4], 4'b0000}, registered at fill start.
REQ-016 The block SHALL have exactly two states: IDLE and FILL.
REQ-017 In IDLE with miss_detected=1, the block SHALL latch base, clear req_cnt (4 bits) and rcv_cnt (3 bits), and enter FILL next cycle.
REQ-018 In IDLE with miss_detected=0, the block SHALL stay in IDLE; memory_data_valid SHALL be ignored in IDLE.
REQ-019 fsm_busy SHALL be 1 exactly while state=FILL.
REQ-020 In FILL with req_cnt<8, the block SHALL drive memory_read=1 and memory_address=base+2*req_cnt, and increment req_cnt; one request per cycle, no gaps.
REQ-021 In FILL with req_cnt=8, memory_read SHALL be 0; memory_read SHALL be 0 in IDLE.
REQ-022 Memory is pipelined with fixed 4-cycle latency; the block SHALL NOT depend on that latency and SHALL count memory_data_valid pulses only.
REQ-023 In FILL with memory_data_valid=1, the block SHALL drive write_data_array=1 and word_num=rcv_cnt, and increment rcv_cnt (mod 8).
REQ-024 cache_address SHALL equal {base[15:4], rcv_cnt, 1'b0} in FILL and miss_address in IDLE.
REQ-025 cache_data_out SHALL equal memory_data_in, combinationally, in all states.
REQ-026 When memory_data_valid=1 and rcv_cnt=7 in FILL, the block SHALL assert write_tag_array=1 in the same cycle as the 8th data write and return to IDLE next cycle.
REQ-027 write_data_array, write_tag_array, and memory_read SHALL be 0 whenever not required by REQ-020, REQ-023, or REQ-026.
REQ-028 miss_detected asserted during FILL SHALL be ignored; a new fill may start only from IDLE, earliest the cycle after returning.
REQ-029 Valid data arriving while requests are still being issued SHALL be written normally; request issue and data receive are concurrent.
REQ-030 The addressed line SHALL never wrap past the 16-byte line boundary: base+14 is the last request.

Reset
REQ-031 rst=1 SHALL, at the next clk edge, force state=IDLE, req_cnt=0, rcv_cnt=0, base=0, regardless of state, including mid-fill.
REQ-032 With the block in IDLE (after reset or otherwise), the outputs SHALL be: fsm_busy=0, memory_read=0, write_data_array=0, write_tag_array=0, word_num=0, memory_address=0, and cache_address=miss_address.
REQ-033 An abandoned fill SHALL leave write_tag_array unasserted, so the partial line is never marked valid.

Verification
REQ-034 Basic fill: miss at cycle 0 with miss_address=0x1236 and 4-cycle memory -> reads at 0x1230..0x123E over cycles 1-8; write_data_array on cycles 5-12 with word_num 0..7; write_tag_array on cycle 12 only; fsm_busy high over cycles 1-12; IDLE at 13.
REQ-035 Back-to-back misses: second miss asserted on cycle 13 at address 0xABC0 -> new fill starts cycle 14 with reads at 0xABC0..0xABCE.
REQ-036 Ignored events: miss_detected held high through the fill, plus a memory_data_valid pulse in IDLE -> exactly one fill, and no writes from the stray pulse.
REQ-037 Reset mid-fill: rst=1 on cycle 7 -> cycle 8 is IDLE with all strobes 0 and no tag write; a subsequent miss refills from word 0.
REQ-038 Irregular memory: memory_data_valid gapped (e.g. 1,0,1,1,0,...) -> word_num increments only on valid; the tag is written with the 8th valid.
